// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, programmable baud divisor, status/IRQ.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_rw,
    input  logic [3:0]  io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        uart_txd,
    output logic        tx_irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef UART_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    localparam logic PARITY_EN = 1'b0;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [DIV_W-1:0]   bit_div_reg, bit_div_next;
    logic [2:0]         bit_idx_reg, bit_idx_next;
    logic [7:0]         data_reg, data_next;
    logic               txd_reg, txd_next;
    logic [DIV_W-1:0]   div_reg;
    logic               overflow_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [7:0]         fifo_mem [FIFO_DEPTH];

    logic fifo_empty, fifo_full, pop, push_ok, bit_end;
    logic wr_txdata, wr_status, wr_div;
    logic unused_wdata;

    assign fifo_empty   = (count_reg == '0);
    assign fifo_full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign wr_txdata    = io_rw && (io_addr == 4'h0);
    assign wr_status    = io_rw && (io_addr == 4'h4);
    assign wr_div       = io_rw && (io_addr == 4'h8);
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign push_ok      = wr_txdata && (!fifo_full || pop);
    assign bit_end      = (bit_cnt_reg == '0);
    assign unused_wdata = ^io_wdata;

    assign uart_txd = txd_reg;
    assign tx_irq   = fifo_empty && (state_reg == IDLE);

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        bit_idx_next = bit_idx_reg;
        data_next    = data_reg;
        bit_div_next = bit_div_reg;
        txd_next     = txd_reg;
        pop          = 1'b0;
        case (state_reg)
            IDLE: begin
                txd_next = 1'b1;
                pop      = !fifo_empty;
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = bit_div_reg - DIV_W'(1);
                    bit_idx_next = 3'd0;
                    txd_next     = data_reg[0];
                end else begin
                    bit_cnt_next = bit_cnt_reg - DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_next = bit_div_reg - DIV_W'(1);
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_next = PARITY;
                        txd_next   = ^data_reg;
`else
                        state_next = STOP;
                        txd_next   = 1'b1;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        txd_next     = data_reg[bit_idx_reg + 3'd1];
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - DIV_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next   = STOP;
                    bit_cnt_next = bit_div_reg - DIV_W'(1);
                    txd_next     = 1'b1;
                end else begin
                    bit_cnt_next = bit_cnt_reg - DIV_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // Queued byte goes straight into the next start bit: no idle gap.
                    pop = !fifo_empty;
                    if (fifo_empty) begin
                        state_next = IDLE;
                        txd_next   = 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - DIV_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase
        if (pop) begin
            state_next   = START;
            data_next    = fifo_mem[rd_ptr_reg];
            bit_div_next = div_reg;
            bit_cnt_next = div_reg - DIV_W'(1);
            txd_next     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_reg  <= '0;
            bit_div_reg  <= DIV_W'(DEFAULT_DIV);
            bit_idx_reg  <= 3'd0;
            data_reg     <= 8'd0;
            txd_reg      <= 1'b1;
            div_reg      <= DIV_W'(DEFAULT_DIV);
            overflow_reg <= 1'b0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            bit_cnt_reg <= bit_cnt_next;
            bit_div_reg <= bit_div_next;
            bit_idx_reg <= bit_idx_next;
            data_reg    <= data_next;
            txd_reg     <= txd_next;
            if (wr_div) begin
                div_reg <= (io_wdata[DIV_W-1:0] == '0) ? DIV_W'(1) : io_wdata[DIV_W-1:0];
            end
            if (wr_txdata && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end else if (wr_status && io_wdata[3]) begin
                overflow_reg <= 1'b0;
            end
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= io_wdata[7:0];
        end
    end

    always_comb begin
        io_rdata = '0;
        case (io_addr)
            4'h4: begin
                io_rdata[0]    = (state_reg != IDLE);
                io_rdata[1]    = fifo_full;
                io_rdata[2]    = fifo_empty;
                io_rdata[3]    = overflow_reg;
                io_rdata[4]    = PARITY_EN;
                io_rdata[11:8] = 4'(count_reg);
            end
            4'h8: io_rdata[DIV_W-1:0] = div_reg;
            default: io_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx: registers, frame timing, FIFO, overflow, reset.
module tb_mmio_uart_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        io_rw = 1'b0;
    logic [3:0]  io_addr = 4'h0;
    logic [31:0] io_wdata = 32'h0;
    logic [31:0] io_rdata;
    logic        uart_txd;
    logic        tx_irq;

    int total = 0;
    int bad = 0;

`ifdef UART_PARITY_EN
    localparam int PAR = 1;
    localparam logic [31:0] PBIT = 32'h10;
`else
    localparam int PAR = 0;
    localparam logic [31:0] PBIT = 32'h0;
`endif

    mmio_uart_tx #(.FIFO_DEPTH(8), .DIV_W(16), .DEFAULT_DIV(868)) dut (
        .clk(clk), .rst_n(rst_n), .io_rw(io_rw), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .uart_txd(uart_txd), .tx_irq(tx_irq)
    );

    always #5 clk = ~clk;

    // Caller sits at a negedge; the write lands on the following posedge.
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        io_rw = 1'b1; io_addr = a; io_wdata = d;
        @(negedge clk);
        io_rw = 1'b0; io_wdata = 32'h0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        io_addr = a;
        #1;
        d = io_rdata;
    endtask

    function automatic int flen(input int div);
        return (10 + PAR) * div;
    endfunction

    // Expected line level k cycles into a frame of byte d at divisor div.
    function automatic logic exp_bit(input logic [7:0] d, input int div, input int k);
        int idx;
        idx = k / div;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (PAR == 1 && idx == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd(4'h4, r); total++;
        if (r !== (32'h4 | PBIT)) begin bad++; $display("FAIL reset_status got=%h want=%h", r, 32'h4 | PBIT); end
        rd(4'h8, r); total++;
        if (r !== 32'd868) begin bad++; $display("FAIL reset_div got=%0d want=868", r); end
        rd(4'h0, r); total++;
        if (r !== 32'h0) begin bad++; $display("FAIL reset_txdata_read got=%h want=0", r); end
        total++;
        if (uart_txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b want=1", uart_txd); end
        total++;
        if (tx_irq !== 1'b1) begin bad++; $display("FAIL reset_irq got=%b want=1", tx_irq); end
        $display("reset: status/div/txd/irq checked");
    endtask

    task automatic test_single_frame();
        logic [31:0] r;
        int errs;
        int first;
        @(negedge clk);
        wr(4'h8, 32'd4);
        wr(4'h0, 32'hA5);
        rd(4'h4, r); total++;
        if (r !== (32'h100 | PBIT)) begin bad++; $display("FAIL single_queued_status got=%h want=%h", r, 32'h100 | PBIT); end
        total++;
        if (tx_irq !== 1'b0) begin bad++; $display("FAIL single_irq_queued got=%b want=0", tx_irq); end
        @(negedge clk);
        errs = 0; first = -1;
        for (int k = 0; k < flen(4); k++) begin
            if (uart_txd !== exp_bit(8'hA5, 4, k) || tx_irq !== 1'b0) begin
                if (errs == 0) first = k;
                errs++;
            end
            @(negedge clk);
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL single_frame_a5 bad_cycles=%0d first_cycle=%0d want=0", errs, first); end
        total++;
        if (uart_txd !== 1'b1 || tx_irq !== 1'b1) begin
            bad++; $display("FAIL single_after_stop txd=%b irq=%b want txd=1 irq=1", uart_txd, tx_irq);
        end
        rd(4'h4, r); total++;
        if (r !== (32'h4 | PBIT)) begin bad++; $display("FAIL single_final_status got=%h want=%h", r, 32'h4 | PBIT); end
        $display("single_frame: data=a5 div=4 bad_cycles=%0d", errs);
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int errs;
        int first;
        logic [7:0] d;
        @(negedge clk);
        wr(4'h8, 32'd2);
        wr(4'h0, 32'h55);
        wr(4'h0, 32'h0F);
        errs = 0; first = -1;
        for (int k = 0; k < 2 * flen(2); k++) begin
            d = (k < flen(2)) ? 8'h55 : 8'h0F;
            if (uart_txd !== exp_bit(d, 2, k % flen(2))) begin
                if (errs == 0) first = k;
                errs++;
            end
            @(negedge clk);
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL b2b_frames bad_cycles=%0d first_cycle=%0d want=0", errs, first); end
        total++;
        if (tx_irq !== 1'b1) begin bad++; $display("FAIL b2b_irq_after got=%b want=1", tx_irq); end
        rd(4'h4, r); total++;
        if (r !== (32'h4 | PBIT)) begin bad++; $display("FAIL b2b_status got=%h want=%h", r, 32'h4 | PBIT); end
        $display("back_to_back: 55,0f div=2 bad_cycles=%0d", errs);
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        @(negedge clk);
        wr(4'h8, 32'd100);
        for (int i = 0; i < 9; i++) wr(4'h0, 32'(i + 1));
        rd(4'h4, r); total++;
        if (r !== (32'h803 | PBIT)) begin bad++; $display("FAIL ovf_nine_pushes got=%h want=%h", r, 32'h803 | PBIT); end
        total++;
        if (uart_txd !== 1'b0) begin bad++; $display("FAIL ovf_start_bit got=%b want=0", uart_txd); end
        wr(4'h0, 32'hEE);
        rd(4'h4, r); total++;
        if (r !== (32'h80B | PBIT)) begin bad++; $display("FAIL ovf_set got=%h want=%h", r, 32'h80B | PBIT); end
        wr(4'h4, 32'h7);
        rd(4'h4, r); total++;
        if (r !== (32'h80B | PBIT)) begin bad++; $display("FAIL ovf_keep got=%h want=%h", r, 32'h80B | PBIT); end
        wr(4'h4, 32'h8);
        rd(4'h4, r); total++;
        if (r !== (32'h803 | PBIT)) begin bad++; $display("FAIL ovf_clear got=%h want=%h", r, 32'h803 | PBIT); end
        $display("overflow: 9 pushes accepted, 10th dropped, sticky flag cleared");
        do_reset();
    endtask

    task automatic test_div_change();
        logic [31:0] r;
        int errs;
        int first;
        int n1;
        @(negedge clk);
        wr(4'h8, 32'd0);
        rd(4'h8, r); total++;
        if (r !== 32'd1) begin bad++; $display("FAIL div_zero got=%0d want=1", r); end
        wr(4'h8, 32'd4);
        wr(4'h0, 32'h3C);
        wr(4'h0, 32'hC3);
        wr(4'h8, 32'd8);
        // Now one cycle into the 0x3C frame, which must keep divisor 4.
        n1 = flen(4);
        errs = 0; first = -1;
        for (int k = 1; k < n1 + flen(8); k++) begin
            if (uart_txd !== ((k < n1) ? exp_bit(8'h3C, 4, k) : exp_bit(8'hC3, 8, k - n1))) begin
                if (errs == 0) first = k;
                errs++;
            end
            @(negedge clk);
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL div_midframe bad_cycles=%0d first_cycle=%0d want=0", errs, first); end
        total++;
        if (tx_irq !== 1'b1) begin bad++; $display("FAIL div_irq_after got=%b want=1", tx_irq); end
        rd(4'h8, r); total++;
        if (r !== 32'd8) begin bad++; $display("FAIL div_readback got=%0d want=8", r); end
        $display("div_change: 3c@4 then c3@8 bad_cycles=%0d", errs);
    endtask

    task automatic test_reset_midframe();
        logic [31:0] r;
        int errs;
        @(negedge clk);
        wr(4'h8, 32'd4);
        wr(4'h0, 32'h11);
        wr(4'h0, 32'h22);
        wr(4'h0, 32'h33);
        wr(4'h0, 32'h44);
        rd(4'h4, r); total++;
        if (r !== (32'h301 | PBIT)) begin bad++; $display("FAIL rst_mid_status_before got=%h want=%h", r, 32'h301 | PBIT); end
        repeat (7) @(negedge clk);
        total++;
        if (uart_txd !== 1'b0) begin bad++; $display("FAIL rst_mid_data_bit1 got=%b want=0", uart_txd); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (uart_txd !== 1'b1 || tx_irq !== 1'b1) begin
            bad++; $display("FAIL rst_mid_line txd=%b irq=%b want txd=1 irq=1", uart_txd, tx_irq);
        end
        rd(4'h4, r); total++;
        if (r !== (32'h4 | PBIT)) begin bad++; $display("FAIL rst_mid_status got=%h want=%h", r, 32'h4 | PBIT); end
        errs = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || io_rdata !== (32'h4 | PBIT)) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL rst_mid_quiet bad_cycles=%0d want=0", errs); end
        $display("reset_midframe: 3 queued bytes discarded, line idle");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_div_change();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
